// File: rtl/decode_rename_pkg.sv
// Shared types and constants for the decode/rename stage pair.
package decode_rename_pkg;

    localparam int unsigned NUM_ARCH = 32;
    localparam int unsigned NUM_PHYS = 64;
    localparam int unsigned PW       = $clog2(NUM_PHYS);
    localparam int unsigned AW       = $clog2(NUM_ARCH);
    localparam int unsigned FL_DEPTH = NUM_PHYS - NUM_ARCH;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_XOR = 3'd2,
        ALU_AND = 3'd3,
        ALU_SRA = 3'd4
    } alu_op_e;

    typedef struct packed {
        logic [31:0]   instr;
        logic [6:0]    opcode;
        alu_op_e       alu_op;
        logic [31:0]   imm;
        logic          use_imm;
        logic          is_load;
        logic          is_store;
        logic [PW-1:0] ps1;
        logic [PW-1:0] ps2;
        logic [PW-1:0] pd;
        logic [PW-1:0] old_pd;
        logic          writes_rd;
        logic          illegal;
    } renamed_uop_t;

endpackage

// File: rtl/decode_rename_if.sv
// Fetch-in, dispatch-out and retire-free signals of the decode/rename stage.
interface decode_rename_if;
    import decode_rename_pkg::*;

    logic          in_valid;
    logic [31:0]   in_instr;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [6:0]    out_opcode;
    alu_op_e       out_alu_op;
    logic [31:0]   out_imm;
    logic          out_use_imm;
    logic          out_is_load;
    logic          out_is_store;
    logic [PW-1:0] out_ps1;
    logic [PW-1:0] out_ps2;
    logic [PW-1:0] out_pd;
    logic [PW-1:0] out_old_pd;
    logic          out_writes_rd;
    logic          out_illegal;
    logic          free_valid;
    logic [PW-1:0] free_preg;

    modport master (
        output in_valid, in_instr, out_ready, free_valid, free_preg,
        input  in_ready, out_valid, out_instr, out_opcode, out_alu_op, out_imm,
               out_use_imm, out_is_load, out_is_store, out_ps1, out_ps2,
               out_pd, out_old_pd, out_writes_rd, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, out_ready, free_valid, free_preg,
        output in_ready, out_valid, out_instr, out_opcode, out_alu_op, out_imm,
               out_use_imm, out_is_load, out_is_store, out_ps1, out_ps2,
               out_pd, out_old_pd, out_writes_rd, out_illegal
    );

endinterface

// File: rtl/decode_rename_free_list.sv
// Circular FIFO of free physical registers; resets holding p32..p63 in order.
module decode_rename_free_list
    import decode_rename_pkg::*;
#(
    localparam int unsigned FW = $clog2(FL_DEPTH),
    localparam int unsigned CW = FW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_pop,
    input  logic          i_push,
    input  logic [PW-1:0] i_push_preg,
    output logic [PW-1:0] o_head_c,
    output logic [CW-1:0] o_count
);

    logic [PW-1:0] r_mem [FL_DEPTH];
    logic [FW-1:0] r_head;
    logic [FW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    // p0 is the hardwired x0 mapping and must never re-enter the list
    assign w_push   = i_push && (i_push_preg != '0) && (r_count != CW'(FL_DEPTH));
    assign w_pop    = i_pop && (r_count != '0);
    assign o_head_c = r_mem[r_head];
    assign o_count  = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FL_DEPTH); i++) begin
                r_mem[i] <= PW'(int'(NUM_ARCH) + i);
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= CW'(FL_DEPTH);
        end else begin
            if (w_pop) begin
                r_head <= r_head + FW'(1);
            end
            if (w_push) begin
                r_mem[r_tail] <= i_push_preg;
                r_tail        <= r_tail + FW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && (i_push_preg != '0) && (r_count == CW'(FL_DEPTH))));

endmodule

// File: rtl/decode_rename.sv
// Decode of the RV32I subset plus RAT/free-list rename, one registered micro-op per cycle.
module decode_rename
    import decode_rename_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    decode_rename_if.slave  bus
);

    function automatic renamed_uop_t decode(input logic [31:0] instr);
        renamed_uop_t u;
        logic [6:0]   f7;
        logic [2:0]   f3;
        f7         = instr[31:25];
        f3         = instr[14:12];
        u          = '0;
        u.instr    = instr;
        u.opcode   = instr[6:0];
        u.alu_op   = ALU_ADD;
        u.illegal  = 1'b1;
        case (instr[6:0])
            OP_R: begin
                u.illegal = 1'b0;
                if      (f7 == 7'b0000000 && f3 == 3'b000) u.alu_op = ALU_ADD;
                else if (f7 == 7'b0100000 && f3 == 3'b000) u.alu_op = ALU_SUB;
                else if (f7 == 7'b0000000 && f3 == 3'b100) u.alu_op = ALU_XOR;
                else if (f7 == 7'b0100000 && f3 == 3'b101) u.alu_op = ALU_SRA;
                else                                       u.illegal = 1'b1;
            end
            OP_I: begin
                if (f3 == 3'b000 || f3 == 3'b111) begin
                    u.illegal = 1'b0;
                    u.alu_op  = (f3 == 3'b111) ? ALU_AND : ALU_ADD;
                    u.use_imm = 1'b1;
                    u.imm     = {{20{instr[31]}}, instr[31:20]};
                end
            end
            OP_LOAD: begin
                if (f3 == 3'b010) begin
                    u.illegal = 1'b0;
                    u.is_load = 1'b1;
                    u.use_imm = 1'b1;
                    u.imm     = {{20{instr[31]}}, instr[31:20]};
                end
            end
            OP_STORE: begin
                if (f3 == 3'b010) begin
                    u.illegal  = 1'b0;
                    u.is_store = 1'b1;
                    u.use_imm  = 1'b1;
                    u.imm      = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                end
            end
            default: u.illegal = 1'b1;
        endcase
        return u;
    endfunction

    localparam int unsigned CW = $clog2(FL_DEPTH) + 1;

    logic [PW-1:0] r_rat [NUM_ARCH];
    renamed_uop_t  r_uop;
    logic          r_valid;
    renamed_uop_t  w_dec;
    renamed_uop_t  w_uop;
    logic [AW-1:0] w_rd;
    logic [AW-1:0] w_rs1;
    logic [AW-1:0] w_rs2;
    logic          w_writes_rd;
    logic          w_i_type;
    logic          w_in_ready;
    logic          w_accept;
    logic [PW-1:0] w_fl_head;
    logic [CW-1:0] w_fl_count;

    assign w_dec       = decode(bus.in_instr);
    assign w_rd        = bus.in_instr[11:7];
    assign w_rs1       = bus.in_instr[19:15];
    assign w_rs2       = bus.in_instr[24:20];
    assign w_writes_rd = !w_dec.illegal && !w_dec.is_store && (w_rd != '0);
    assign w_i_type    = w_dec.use_imm && !w_dec.is_store;
    assign w_in_ready  = (!r_valid || bus.out_ready) && !(w_writes_rd && (w_fl_count == '0));
    assign w_accept    = bus.in_valid && w_in_ready;

    // Rename lookup reads the pre-update RAT so rd==rs sees the old mapping
    always_comb begin
        w_uop           = w_dec;
        w_uop.ps1       = r_rat[w_rs1];
        w_uop.ps2       = w_i_type ? '0 : r_rat[w_rs2];
        w_uop.writes_rd = w_writes_rd;
        w_uop.pd        = w_writes_rd ? w_fl_head : '0;
        w_uop.old_pd    = w_writes_rd ? r_rat[w_rd] : '0;
    end

    decode_rename_free_list u_free_list (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_pop       (w_accept && w_writes_rd),
        .i_push      (bus.free_valid),
        .i_push_preg (bus.free_preg),
        .o_head_c    (w_fl_head),
        .o_count     (w_fl_count)
    );

    // x0 is never a rename target, so RAT[0] stays at its reset value of 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_ARCH); i++) begin
                r_rat[i] <= PW'(i);
            end
        end else if (w_accept && w_writes_rd) begin
            r_rat[w_rd] <= w_fl_head;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_uop   <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_uop   <= w_uop;
        end else if (bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.out_valid     = r_valid;
    assign bus.out_instr     = r_uop.instr;
    assign bus.out_opcode    = r_uop.opcode;
    assign bus.out_alu_op    = r_uop.alu_op;
    assign bus.out_imm       = r_uop.imm;
    assign bus.out_use_imm   = r_uop.use_imm;
    assign bus.out_is_load   = r_uop.is_load;
    assign bus.out_is_store  = r_uop.is_store;
    assign bus.out_ps1       = r_uop.ps1;
    assign bus.out_ps2       = r_uop.ps2;
    assign bus.out_pd        = r_uop.pd;
    assign bus.out_old_pd    = r_uop.old_pd;
    assign bus.out_writes_rd = r_uop.writes_rd;
    assign bus.out_illegal   = r_uop.illegal;

endmodule

// File: tb/tb_decode_rename.sv
// Randomized bench for decode_rename against a mnemonic-level rename model.
module tb_decode_rename;
    import decode_rename_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    decode_rename_if bus();

    decode_rename dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    typedef enum {M_ADD, M_SUB, M_XOR, M_SRA, M_ADDI, M_ANDI, M_LW, M_SW, M_ILL} mn_e;

    // Reference state: architectural map, free-register queue, retirement queue
    int rat [32];
    int fl [$];
    int retire_q [$];

    bit          e_valid;
    logic [31:0] e_instr, e_imm;
    int          e_alu, e_ps1, e_ps2, e_pd, e_old;
    bit          e_use, e_ld, e_st, e_wr, e_ill;

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) rat[i] = i;
        fl.delete();
        for (int i = 32; i < 64; i++) fl.push_back(i);
        retire_q.delete();
        e_valid = 0;
    endfunction

    function automatic mn_e classify(input logic [31:0] w);
        if ((w & 32'hFE00707F) == 32'h00000033) return M_ADD;
        if ((w & 32'hFE00707F) == 32'h40000033) return M_SUB;
        if ((w & 32'hFE00707F) == 32'h00004033) return M_XOR;
        if ((w & 32'hFE00707F) == 32'h40005033) return M_SRA;
        if ((w & 32'h0000707F) == 32'h00000013) return M_ADDI;
        if ((w & 32'h0000707F) == 32'h00007013) return M_ANDI;
        if ((w & 32'h0000707F) == 32'h00002003) return M_LW;
        if ((w & 32'h0000707F) == 32'h00002023) return M_SW;
        return M_ILL;
    endfunction

    function automatic logic [31:0] imm_of(input mn_e m, input logic [31:0] w);
        logic signed [11:0] s;
        if (m == M_ADDI || m == M_ANDI || m == M_LW) begin
            s = w[31:20];
            return 32'(s);
        end
        if (m == M_SW) begin
            s = {w[31:25], w[11:7]};
            return 32'(s);
        end
        return 32'h0;
    endfunction

    function automatic int alu_of(input mn_e m);
        case (m)
            M_SUB:  return 1;
            M_XOR:  return 2;
            M_ANDI: return 3;
            M_SRA:  return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), OP_R};
    endfunction

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
        return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
        logic [11:0] im;
        im = 12'(imm);
        return {im[11:5], 5'(rs2), 5'(rs1), 3'b010, im[4:0], OP_STORE};
    endfunction

    function automatic logic [31:0] rand_instr();
        int rd, rs1, rs2, imm;
        rd  = $urandom_range(0, 31);
        rs1 = $urandom_range(0, 31);
        rs2 = $urandom_range(0, 31);
        imm = $urandom_range(0, 4095);
        case ($urandom_range(0, 9))
            0: return enc_r(0, rs2, rs1, 0, rd);
            1: return enc_r(32, rs2, rs1, 0, rd);
            2: return enc_r(0, rs2, rs1, 4, rd);
            3: return enc_r(32, rs2, rs1, 5, rd);
            4: return enc_i(imm, rs1, 0, rd, OP_I);
            5: return enc_i(imm, rs1, 7, rd, OP_I);
            6: return enc_i(imm, rs1, 2, rd, OP_LOAD);
            7: return enc_s(imm, rs2, rs1);
            8: return $urandom;
            default: return enc_r(1, rs2, rs1, 0, rd);
        endcase
    endfunction

    task automatic drive(input bit v, input logic [31:0] ins, input bit ordy, input bit fv, input int fp);
        bus.in_valid   = v;
        bus.in_instr   = ins;
        bus.out_ready  = ordy;
        bus.free_valid = fv;
        bus.free_preg  = PW'(fp);
    endtask

    task automatic check_outputs();
        check("out_valid", 32'(bus.out_valid), 32'(e_valid));
        if (e_valid) begin
            check("out_instr",     bus.out_instr,              e_instr);
            check("out_opcode",    32'(bus.out_opcode),        32'(e_instr[6:0]));
            check("out_illegal",   32'(bus.out_illegal),       32'(e_ill));
            check("out_alu_op",    32'(bus.out_alu_op),        32'(e_alu));
            check("out_imm",       bus.out_imm,                e_imm);
            check("out_use_imm",   32'(bus.out_use_imm),       32'(e_use));
            check("out_is_load",   32'(bus.out_is_load),       32'(e_ld));
            check("out_is_store",  32'(bus.out_is_store),      32'(e_st));
            check("out_writes_rd", 32'(bus.out_writes_rd),     32'(e_wr));
            check("out_pd",        32'(bus.out_pd),            32'(e_pd));
            check("out_old_pd",    32'(bus.out_old_pd),        32'(e_old));
            if (!e_ill) begin
                check("out_ps1", 32'(bus.out_ps1), 32'(e_ps1));
                check("out_ps2", 32'(bus.out_ps2), 32'(e_ps2));
            end
        end
    endtask

    // One clock: predict in_ready before the edge, advance the model, compare after
    task automatic step();
        mn_e m;
        bit  wr, rdy, acc, full_before;
        int  rd, rs1, rs2;
        @(negedge clk);
        m   = classify(bus.in_instr);
        rd  = int'(bus.in_instr[11:7]);
        rs1 = int'(bus.in_instr[19:15]);
        rs2 = int'(bus.in_instr[24:20]);
        wr  = (m != M_ILL) && (m != M_SW) && (rd != 0);
        rdy = (!e_valid || bus.out_ready) && !(wr && fl.size() == 0);
        check("in_ready", 32'(bus.in_ready), 32'(rdy));
        acc         = bus.in_valid && rdy;
        full_before = (fl.size() >= 32);
        @(posedge clk);
        #1;
        if (acc) begin
            e_valid = 1;
            e_instr = bus.in_instr;
            e_ill   = (m == M_ILL);
            e_alu   = alu_of(m);
            e_imm   = imm_of(m, bus.in_instr);
            e_use   = (m == M_ADDI) || (m == M_ANDI) || (m == M_LW) || (m == M_SW);
            e_ld    = (m == M_LW);
            e_st    = (m == M_SW);
            e_wr    = wr;
            e_ps1   = rat[rs1];
            e_ps2   = (m == M_ADDI || m == M_ANDI || m == M_LW) ? 0 : rat[rs2];
            if (wr) begin
                e_pd    = fl.pop_front();
                e_old   = rat[rd];
                rat[rd] = e_pd;
                retire_q.push_back(e_old);
            end else begin
                e_pd  = 0;
                e_old = 0;
            end
        end else if (bus.out_ready) begin
            e_valid = 0;
        end
        if (bus.free_valid && bus.free_preg != '0 && !full_before) fl.push_back(int'(bus.free_preg));
        check_outputs();
    endtask

    task automatic do_reset();
        #3 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_out_pd",    32'(bus.out_pd),    32'h0);
        check("rst_out_instr", bus.out_instr,      32'h0);
        model_reset();
        drive(0, 32'h0, 1, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int fp;
        bit fv;
        rst_n = 1'b1;
        model_reset();
        drive(0, 32'h0, 1, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        check("init_out_valid", 32'(bus.out_valid), 32'h0);
        check("init_out_imm",   bus.out_imm,        32'h0);
        check("init_in_ready",  32'(bus.in_ready),  32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        drive(1, 32'h002081B3, 1, 0, 0); step();
        check("t1_ps1", 32'(bus.out_ps1), 32'd1);
        check("t1_ps2", 32'(bus.out_ps2), 32'd2);
        check("t1_pd",  32'(bus.out_pd),  32'd32);
        check("t1_old", 32'(bus.out_old_pd), 32'd3);
        drive(1, 32'h00318233, 1, 0, 0); step();
        check("t2_ps1", 32'(bus.out_ps1), 32'd32);
        check("t2_ps2", 32'(bus.out_ps2), 32'd32);
        check("t2_pd",  32'(bus.out_pd),  32'd33);
        check("t2_old", 32'(bus.out_old_pd), 32'd4);
        drive(1, 32'hFFF00293, 1, 0, 0); step();
        check("t3_imm", bus.out_imm, 32'hFFFFFFFF);
        check("t3_ps1", 32'(bus.out_ps1), 32'd0);
        check("t3_pd",  32'(bus.out_pd),  32'd34);
        drive(1, 32'h0020A423, 1, 0, 0); step();
        check("t4_imm", bus.out_imm, 32'd8);
        check("t4_wr",  32'(bus.out_writes_rd), 32'd0);
        check("t4_pd",  32'(bus.out_pd),  32'd0);
        drive(1, enc_r(0, 2, 1, 0, 6), 1, 0, 0); step();
        check("t4_free_unchanged", 32'(bus.out_pd), 32'd35);

        // Exhaust the free list, then free p3 and see it reused
        do_reset();
        for (int i = 0; i < 32; i++) begin
            drive(1, enc_r(0, 2, 1, 0, (i % 31) + 1), 1, 0, 0);
            step();
        end
        drive(1, enc_r(0, 2, 1, 0, 7), 1, 0, 0);
        #1 check("empty_in_ready", 32'(bus.in_ready), 32'h0);
        step();
        drive(1, enc_r(0, 2, 1, 0, 7), 1, 1, 3); step();
        drive(1, enc_r(0, 2, 1, 0, 7), 1, 0, 0); step();
        check("reuse_pd", 32'(bus.out_pd), 32'd3);

        // Stall with a valid output held
        for (int i = 0; i < 3; i++) begin
            drive(1, enc_r(0, 3, 4, 4, 9 + i), 0, 0, 0);
            step();
        end
        check("stall_pd", 32'(bus.out_pd), 32'd3);
        drive(1, 32'hFFFFFFFF, 1, 0, 0); step();
        check("ill_flag", 32'(bus.out_illegal), 32'h1);
        check("ill_pd",   32'(bus.out_pd),      32'h0);
        drive(1, 32'h00208033, 1, 0, 0); step();
        check("x0_wr", 32'(bus.out_writes_rd), 32'h0);
        check("x0_pd", 32'(bus.out_pd),        32'h0);

        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                do_reset();
                drive(1, 32'h002081B3, 1, 0, 0); step();
                check("post_rst_pd", 32'(bus.out_pd), 32'd32);
            end
            fv = 0;
            fp = 0;
            if (retire_q.size() > 0 && fl.size() < 32 && $urandom_range(0, 2) == 0) begin
                fv = 1;
                fp = retire_q.pop_front();
            end else if ($urandom_range(0, 15) == 0) begin
                fv = 1;
            end
            drive($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0, fv, fp);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
